// File: rtl/bus_ram_pkg.sv
// rtl/bus_ram_pkg.sv - shared CPU memory bus widths and bus_ram state encoding
package bus_ram_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;
  localparam int BYTE_W     = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } ram_state_t;

endpackage

// File: rtl/bus_ram_if.sv
// rtl/bus_ram_if.sv - CPU memory bus: requester (master) and responder (slave) views
interface bus_ram_if;
  import bus_ram_pkg::*;

  logic                  ready;
  logic [BUS_ADDR_W-1:0] addr;
  logic [BUS_DATA_W-1:0] write_data;
  logic [BUS_BE_W-1:0]   byte_enable;
  logic                  write_req;
  logic                  read_req;
  logic [BUS_DATA_W-1:0] read_data;
  logic                  read_data_valid;

  modport master (
    input  ready, read_data, read_data_valid,
    output addr, write_data, byte_enable, write_req, read_req
  );

  modport slave (
    output ready, read_data, read_data_valid,
    input  addr, write_data, byte_enable, write_req, read_req
  );

endinterface

// File: rtl/bus_ram_ram_1rw.sv
// rtl/bus_ram_ram_1rw.sv - single-port RAM array, byte-write mask, registered read
module ram_1rw
  import bus_ram_pkg::*;
#(
  parameter int DEPTH_BITS = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [BUS_BE_W-1:0]   be,
  input  logic [BUS_DATA_W-1:0] wdata,
  output logic [BUS_DATA_W-1:0] rdata
);

  logic [BUS_DATA_W-1:0] mem [0:(2**DEPTH_BITS)-1];

  // Array kept reset-free so it maps onto block RAM; contents are zeroed by the clear sequencer.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BUS_BE_W; i++) begin
        if (be[i]) mem[addr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - bus responder RAM with post-reset clear sequencer and fixed read latency
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter int DEPTH_BITS   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  bus_ram_if.slave bus
);

  ram_state_t            state, state_next;
  logic [DEPTH_BITS-1:0] clear_cnt;
  logic                  clearing;
  logic                  ready;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  ram_we;
  logic [DEPTH_BITS-1:0] ram_addr;
  logic [BUS_BE_W-1:0]   ram_be;
  logic [BUS_DATA_W-1:0] ram_wdata;
  logic [BUS_DATA_W-1:0] ram_rdata;
  logic [READ_LATENCY:1] valid_q;
  logic                  unused_addr_bits;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_CLEAR;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clear_cnt == '1) state_next = ST_SERVE;
      ST_SERVE: state_next = ST_SERVE;
      default:  state_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    clearing = 1'b0;
    case (state)
      ST_CLEAR: clearing = 1'b1;
      ST_SERVE: ready    = 1'b1;
      default:  clearing = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)     clear_cnt <= '0;
    else if (clearing) clear_cnt <= clear_cnt + 1'b1;
  end

  // A simultaneous read and write is a write only.
  assign wr_accept = ready & bus.write_req;
  assign rd_accept = ready & bus.read_req & ~bus.write_req;

  always_comb begin
    ram_we    = wr_accept;
    ram_addr  = bus.addr[DEPTH_BITS+1:2];
    ram_be    = bus.byte_enable;
    ram_wdata = bus.write_data;
    if (clearing) begin
      ram_we    = 1'b1;
      ram_addr  = clear_cnt;
      ram_be    = '1;
      ram_wdata = '0;
    end
  end

  assign unused_addr_bits = ^{bus.addr[BUS_ADDR_W-1:DEPTH_BITS+2], bus.addr[1:0]};

  ram_1rw #(.DEPTH_BITS(DEPTH_BITS)) u_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (ram_we),
    .re     (rd_accept),
    .addr   (ram_addr),
    .be     (ram_be),
    .wdata  (ram_wdata),
    .rdata  (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q[1] <= rd_accept;
      for (int k = 2; k <= READ_LATENCY; k++) valid_q[k] <= valid_q[k-1];
    end
  end

  // Each data stage loads only alongside its valid bit, so read_data holds between responses.
  if (READ_LATENCY == 1) begin : g_direct
    assign bus.read_data = ram_rdata;
  end else begin : g_pipe
    logic [BUS_DATA_W-1:0] data_q [2:READ_LATENCY];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int k = 2; k <= READ_LATENCY; k++) data_q[k] <= '0;
      end else begin
        if (valid_q[1]) data_q[2] <= ram_rdata;
        for (int k = 3; k <= READ_LATENCY; k++) begin
          if (valid_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
    end

    assign bus.read_data = data_q[READ_LATENCY];
  end

  assign bus.ready           = ready;
  assign bus.read_data_valid = valid_q[READ_LATENCY];

endmodule

// File: tb/tb_bus_ram.sv
// tb/tb_bus_ram.sv - directed self-checking bench for bus_ram (DEPTH_BITS=12, READ_LATENCY=2)
module tb_bus_ram;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bus_ram_if bus ();

  bus_ram #(.DEPTH_BITS(12), .READ_LATENCY(2)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    bus.write_req   = w;
    bus.read_req    = r;
    bus.addr        = a;
    bus.write_data  = d;
    bus.byte_enable = be;
  endtask

  task automatic idle;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic release_and_count(output int n, output int saw_valid);
    reset_n   = 1'b1;
    n         = 0;
    saw_valid = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) break;
      n++;
      if (bus.read_data_valid !== 1'b0) saw_valid = 1;
      @(posedge clk);
      #1;
    end
    tick();
  endtask

  task automatic test_reset;
    int n, sv;
    reset_n = 1'b0;
    idle();
    tick();
    tick();
    @(negedge clk);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.read_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.read_data_valid); end
    checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", bus.read_data); end
    tick();
    release_and_count(n, sv);
    checks++; if (n !== 4096) begin errors++; $display("FAIL clear_len got=%0d exp=4096", n); end
    checks++; if (sv !== 0) begin errors++; $display("FAIL clear_valid got=%0d exp=0", sv); end
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_after_clear got=%b exp=1", bus.ready); end
    tick();
  endtask

  task automatic test_idle_read;
    set_req(1'b0, 1'b1, 32'h10000ffc, 32'h0, 4'h0);
    tick();
    idle();
    @(negedge clk);
    checks++; if (bus.read_data_valid !== 1'b0) begin errors++; $display("FAIL idle_read_t1 got=%b exp=0", bus.read_data_valid); end
    tick();
    @(negedge clk);
    checks++; if (bus.read_data_valid !== 1'b1) begin errors++; $display("FAIL idle_read_t2_valid got=%b exp=1", bus.read_data_valid); end
    checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL idle_read_data got=%h exp=00000000", bus.read_data); end
    tick();
    @(negedge clk);
    checks++; if (bus.read_data_valid !== 1'b0) begin errors++; $display("FAIL idle_read_t3 got=%b exp=0", bus.read_data_valid); end
    tick();
  endtask

  task automatic test_full_word;
    set_req(1'b1, 1'b0, 32'h10, 32'hdeadbeef, 4'hf);
    tick();
    set_req(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    tick();
    idle();
    @(negedge clk);
    checks++; if (bus.read_data_valid !== 1'b0) begin errors++; $display("FAIL full_word_t2 got=%b exp=0", bus.read_data_valid); end
    tick();
    @(negedge clk);
    checks++; if (bus.read_data_valid !== 1'b1) begin errors++; $display("FAIL full_word_valid got=%b exp=1", bus.read_data_valid); end
    checks++; if (bus.read_data !== 32'hdeadbeef) begin errors++; $display("FAIL full_word_data got=%h exp=deadbeef", bus.read_data); end
    tick();
  endtask

  task automatic test_byte_lanes;
    logic [31:0] wd  [3] = '{32'h0000aa00, 32'hffffffff, 32'ha5000077};
    logic [3:0]  wbe [3] = '{4'b0010, 4'b0000, 4'b1001};
    logic [31:0] exp [3] = '{32'h1122aa44, 32'h1122aa44, 32'ha522aa77};
    set_req(1'b1, 1'b0, 32'h20, 32'h11223344, 4'hf);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b0, 32'h20, wd[i], wbe[i]);
      tick();
      set_req(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
      tick();
      idle();
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++; if (bus.read_data_valid !== 1'b1) begin errors++; $display("FAIL lanes_valid[%0d] got=%b exp=1", i, bus.read_data_valid); end
      checks++; if (bus.read_data !== exp[i]) begin errors++; $display("FAIL lanes_data[%0d] got=%h exp=%h", i, bus.read_data, exp[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b0, 32'(4 * i), 32'(i), 4'hf);
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      if (c < 8) set_req(1'b0, 1'b1, 32'(4 * c), 32'h0, 4'h0);
      else       idle();
      @(negedge clk);
      exp_v = (c >= 2) && (c < 10);
      checks++; if (bus.read_data_valid !== exp_v) begin errors++; $display("FAIL stream_valid[c%0d] got=%b exp=%b", c, bus.read_data_valid, exp_v); end
      if (exp_v) begin
        checks++; if (bus.read_data !== 32'(c - 2)) begin errors++; $display("FAIL stream_data[c%0d] got=%h exp=%h", c, bus.read_data, 32'(c - 2)); end
      end
      tick();
    end
  endtask

  task automatic test_conflict_alias;
    int sv;
    set_req(1'b1, 1'b1, 32'h4000, 32'h55, 4'hf);
    tick();
    idle();
    sv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.read_data_valid !== 1'b0) sv++;
      tick();
    end
    checks++; if (sv !== 0) begin errors++; $display("FAIL conflict_no_valid got=%0d pulses exp=0", sv); end
    set_req(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    idle();
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (bus.read_data_valid !== 1'b1) begin errors++; $display("FAIL alias_valid got=%b exp=1", bus.read_data_valid); end
    checks++; if (bus.read_data !== 32'h55) begin errors++; $display("FAIL alias_data got=%h exp=00000055", bus.read_data); end
    tick();
  endtask

  task automatic test_reset_mid;
    int n, sv;
    set_req(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.read_data_valid !== 1'b0) begin errors++; $display("FAIL midrst_t1 got=%b exp=0", bus.read_data_valid); end
    tick();
    @(negedge clk);
    checks++; if (bus.read_data_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got=%b exp=0", bus.read_data_valid); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL midrst_data got=%h exp=00000000", bus.read_data); end
    tick();
    release_and_count(n, sv);
    checks++; if (n !== 4096) begin errors++; $display("FAIL midrst_clear_len got=%0d exp=4096", n); end
    checks++; if (sv !== 0) begin errors++; $display("FAIL midrst_clear_valid got=%0d exp=0", sv); end
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got=%b exp=1", bus.ready); end
    tick();
    set_req(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    set_req(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.read_data_valid !== 1'b1) begin errors++; $display("FAIL cleared_valid[%0d] got=%b exp=1", i, bus.read_data_valid); end
      checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL cleared_data[%0d] got=%h exp=00000000", i, bus.read_data); end
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    test_reset();
    test_idle_read();
    test_full_word();
    test_byte_lanes();
    test_back_to_back();
    test_conflict_alias();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
